vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480 @ ~60 Hz VGA raster timing from the 50 MHz board clock.
- Derives a 25 MHz pixel-enable strobe and counts pixels/lines. Produces registered HSYNC/VSYNC, an active-video flag, pixel coordinates and frame/line markers.
- Sits directly upstream of the Project4 pixel/colour stage. That stage consumes x/y/active and drives VGA_R/G/B, while HS/VS pass to the VGA_HS/VGA_VS pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, MAX10_CLK1_50 cycles per pixel (>=1)
- SYNC_POL, 0, sync level during sync pulse (0 = active-low)

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- pix_en  out  1  one-clock strobe; high in the cycle each new pixel's outputs become valid
- hsync  out  1  horizontal sync, SYNC_POL during pulse
- vsync  out  1  vertical sync, SYNC_POL during pulse
- active  out  1  high when the current pixel is inside the 640x480 visible area
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- line_start  out  1  high with pix_en when pix_x==0
- frame_start  out  1  high with pix_en when pix_x==0 and pix_y==0
- frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 525.
  - Hsync window [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752).
  - Vsync window [490,492).
- Reset (rst sampled high on a clock edge):
  - Divider = 0, h = 0, v = 0, frame_cnt = 0.
  - pix_en = 0, line_start = 0, frame_start = 0, active = 0.
  - hsync = vsync = ~SYNC_POL; pix_x = pix_y = 0.
  - Reset mid-frame aborts immediately; no partial sync pulse is held.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - "tick" = divider == CLK_DIV-1. With CLK_DIV = 1, every cycle is a tick.
- Counters (update on tick edges only):
  - h increments and wraps at H_TOTAL-1 -> 0.
  - On h wrap, v increments and wraps at V_TOTAL-1 -> 0.
  - On v wrap, frame_cnt increments.
- Outputs:
  - All are registers loaded on the tick edge from the next counter values, so the outputs and the counters are always consistent.
  - pix_en is high for exactly the one cycle following each tick edge, and low otherwise.
  - line_start and frame_start are high only in a pix_en cycle.
  - Between ticks, all other outputs hold.
- First pixel after reset release:
  - The first tick occurs CLK_DIV cycles after the reset edge.
  - Its outputs present h = 1, v = 0, because counters start at 0 and reset itself presents pixel (0,0) with pix_en = 0.
  - frame_start first pulses after one full frame.
- Derived signals:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync/vsync = SYNC_POL inside their windows, ~SYNC_POL elsewhere.
- Latency: colour stage sees coordinates and sync in the same cycle, so a registered colour stage must delay hsync/vsync by one pix_en.
- Frame period = 800*525*CLK_DIV = 840000 clocks = 16.8 ms.
- Reset takes priority over tick in the same cycle.

Decomposition:
- Shared package/include: H_/V_ timing constants, derived totals and sync window bounds, coordinate width (10).
- One sub-module, vga_axis_counter (parameterised TOTAL, SYNC_START, SYNC_END, ACTIVE; inputs en/rst; outputs count, wrap, in_sync, in_active). Instantiated twice: horizontal (en = tick) and vertical (en = tick && h_wrap).
- Divider stays in the top level.

Test Plan:
- Reset then release, count clocks -> first pix_en 2 clocks after release with pix_x=1, pix_y=0; hsync=vsync=1 throughout reset; active=0 during reset.
- Run one line -> pix_en period 2 clocks; hsync low for exactly 96 pix_en (192 clocks), falling when pix_x becomes 656, rising at 752; line period 1600 clocks.
- Run one frame -> vsync low for exactly 2 lines (3200 clocks) starting at pix_y=490; frame_start period 840000 clocks; frame_cnt 0->1.
- Check active -> high for pix_x 0..639 with pix_y 0..479; low at pix_x=640 and at pix_y=480 regardless of x.
- Assert rst mid-frame (pix_y≈300) for 1 clock -> next cycle all outputs at reset values; frame_cnt=0; timing restarts as in scenario 1.
- CLK_DIV=1 build -> pix_en constantly high; line period 800 clocks; hsync width 96 clocks.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared timing constants for the 640x480 @ ~60 Hz VGA raster generator.
// Holds the default porch/sync/active figures, the derived totals and sync
// window bounds, and the coordinate / frame-counter widths used by the top
// level and by the per-axis counter.
// ---------------------------------------------------------------------------
package vga_timing_gen_pkg;

  // Width of pix_x / pix_y and of the internal axis counters.
  localparam int COORD_W     = 10;
  // Width of the completed-frame counter.
  localparam int FRAME_CNT_W = 8;

  // Default horizontal timing, in pixels.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Board clocks per pixel and sync pulse level (0 = active-low pulse).
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_SYNC_POL = 0;

  // Length of one axis: visible + front porch + sync + back porch.
  function automatic int axis_total(input int act, input int fp,
                                    input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Sync pulse occupies [act+fp, act+fp+sync).
  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int sync);
    return act + fp + sync;
  endfunction

  // Derived defaults: 800 x 525, hsync [656,752), vsync [490,492).
  localparam int DEF_H_TOTAL      = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL      = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each enabled
// cycle and wraps.
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset, count returns to 0
//   en        - advance the count at this edge
//   count     - current (registered) count
//   wrap      - count is at TOTAL-1, so the next enabled edge wraps to 0
//   in_sync   - the count loaded at this edge lies in [SYNC_START, SYNC_END)
//   in_active - the count loaded at this edge lies below ACTIVE
//
// in_sync / in_active decode the value the counter is about to hold, not the
// value it holds now. The top level registers them on the same edge as the
// counter advances, so its sync/active flops always agree with count.
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int SYNC_START = DEF_H_SYNC_START,
  parameter int SYNC_END   = DEF_H_SYNC_END,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int W          = COORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_active
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO    = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI    = W'(SYNC_END);
  localparam logic [W-1:0] ACTIVE_LIM = W'(ACTIVE);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign wrap = (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (en) begin
      count_next = wrap ? '0 : count_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign in_sync   = (count_next >= SYNC_LO) && (count_next < SYNC_HI);
  assign in_active = (count_next < ACTIVE_LIM);
  assign count     = count_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480 @ ~60 Hz VGA raster timing from the 50 MHz board clock. A clock
// divider produces a pixel tick every CLK_DIV cycles; two axis counters track
// the horizontal and vertical position. Every output is a flop loaded on the
// tick edge, so coordinates, sync and active always describe the same pixel.
//
// Ports:
//   MAX10_CLK1_50 - 50 MHz system clock
//   rst           - synchronous active-high reset (wins over a same-cycle tick)
//   pix_en        - one-cycle strobe in the cycle a new pixel becomes valid
//   hsync, vsync  - SYNC_POL during the pulse, ~SYNC_POL otherwise
//   active        - current pixel is inside the visible area
//   pix_x, pix_y  - current horizontal / vertical count
//   line_start    - with pix_en when pix_x == 0
//   frame_start   - with pix_en when pix_x == 0 and pix_y == 0
//   frame_cnt     - completed frames, wraps 255 -> 0
//
// Downstream note: the colour stage sees coordinates and sync together, so a
// registered colour stage must delay hsync/vsync by one pix_en to match.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   rst,
  output logic                   pix_en,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   active,
  output logic [COORD_W-1:0]     pix_x,
  output logic [COORD_W-1:0]     pix_y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // A 1-bit divider is kept for CLK_DIV == 1; it simply stays at 0 and every
  // cycle is a tick.
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             SYNC_LVL = (SYNC_POL != 0);

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] div_reg;
  logic             tick;

  assign tick = (div_reg == DIV_LAST);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  // ----------------------------------------------------------- axis counters
  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic               h_wrap;
  logic               v_wrap;
  logic               h_in_sync;
  logic               v_in_sync;
  logic               h_in_active;
  logic               v_in_active;
  logic               v_en;

  // The vertical axis only moves on the tick that wraps the horizontal one.
  assign v_en = tick & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (sync_start(H_ACTIVE, H_FP)),
    .SYNC_END   (sync_end(H_ACTIVE, H_FP, H_SYNC)),
    .ACTIVE     (H_ACTIVE),
    .W          (COORD_W)
  ) u_h_axis (
    .clk       (MAX10_CLK1_50),
    .rst       (rst),
    .en        (tick),
    .count     (h_count),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync),
    .in_active (h_in_active)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (sync_start(V_ACTIVE, V_FP)),
    .SYNC_END   (sync_end(V_ACTIVE, V_FP, V_SYNC)),
    .ACTIVE     (V_ACTIVE),
    .W          (COORD_W)
  ) u_v_axis (
    .clk       (MAX10_CLK1_50),
    .rst       (rst),
    .en        (v_en),
    .count     (v_count),
    .wrap      (v_wrap),
    .in_sync   (v_in_sync),
    .in_active (v_in_active)
  );

  // --------------------------------------------------------- output registers
  logic                   pix_en_reg;
  logic                   line_start_reg;
  logic                   frame_start_reg;
  logic                   hsync_reg;
  logic                   vsync_reg;
  logic                   active_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic                   frame_wrap;

  // Tick that takes the raster from the last pixel of a frame back to (0,0).
  assign frame_wrap = tick & h_wrap & v_wrap;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      pix_en_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hsync_reg       <= ~SYNC_LVL;
      vsync_reg       <= ~SYNC_LVL;
      active_reg      <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      // Strobes are recomputed every cycle so they drop after one clock.
      pix_en_reg      <= tick;
      line_start_reg  <= tick & h_wrap;
      frame_start_reg <= frame_wrap;
      if (tick) begin
        hsync_reg  <= h_in_sync ? SYNC_LVL : ~SYNC_LVL;
        vsync_reg  <= v_in_sync ? SYNC_LVL : ~SYNC_LVL;
        active_reg <= h_in_active & v_in_active;
      end
      if (frame_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
      end
    end
  end

  assign pix_en      = pix_en_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign active      = active_reg;
  assign pix_x       = h_count;
  assign pix_y       = v_count;
  assign frame_cnt   = frame_cnt_reg;

endmodule
